nbody_2x2_scheduler: RTL
========================

# nbody_2x2_scheduler

Sequencing controller for the 2x2 systolic n-body force array and the Verlet integration stage. For each time step it walks the N-body interaction matrix in 2x2 tiles, drives skewed body indices into the array's two lanes, and tells the accumulator which results to capture and when. It then strobes the integrator once per body and repeats for a programmed number of steps. It sits between the body-state memory/feeder and the `systolic_2x2` / integration datapath and carries indices and strobes only, no physics data.

## Interface
- `N_BODIES`, 4, body count; must be even and ≥2
- `ARR_LAT`, 2, cycles from array lane input to `out_pr`/`out_pd` valid
- `IDX_W`, `$clog2(N_BODIES)`, body index width
- `STEP_W`, 16, step counter width
- `clk` input 1: single clock; all logic on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `start` input 1: begin a run; sampled only in IDLE
- `hold` input 1: freeze all state, counters and delay pipes
- `n_steps` input STEP_W: steps to run; sampled with `start`
- `busy` output 1: high in any state except IDLE
- `done` output 1: one-cycle pulse at end of run
- `step_cnt` output STEP_W: completed steps in current run
- `acc_clr` output 1: clear all accelerations (one cycle per step)
- `feed_vld` output 2: per-lane feed strobe (bit k = lane k)
- `feed_i_idx0/1` output IDX_W: row body index, lane 0/1
- `feed_j_idx0/1` output IDX_W: column body index, lane 0/1
- `acc_vld` output 2: per-lane strobe to capture `out_pr_k`/`out_pd_k`
- `acc_i_idx0/1`, `acc_j_idx0/1` output IDX_W: indices the captured results belong to
- `integ_vld` output 1: integrate body `integ_idx` this cycle
- `integ_idx` output IDX_W: body being integrated

## Operation
- States: IDLE, CLR, FEED, DRAIN, INTEG, DONE.
- IDLE: if `start` and `n_steps`==0, go to DONE. If `start` and `n_steps`>0, latch `n_steps`, zero `step_cnt`, go to CLR.
- CLR: `acc_clr`=1 for one cycle, then FEED.
- FEED: tile counter t walks tiles (bi,bj) row-major, bi,bj ∈ [0, N_BODIES/2).
  - Lane 0 presents tile t: i=2bi, j=2bj.
  - Lane 1 presents tile t−1: i=2bi+1, j=2bj+1 (one-cycle skew).
  - FEED lasts T+1 cycles. Lane 0 is idle in the final cycle; lane 1 is idle in the first.
- DRAIN: ARR_LAT cycles, then INTEG.
- `acc_vld`/`acc_*_idx` are `feed_vld`/`feed_*_idx` delayed by exactly ARR_LAT cycles. They may therefore extend into DRAIN.
- INTEG: `integ_idx` counts 0..N_BODIES−1 with `integ_vld`=1. On the last body, `step_cnt` increments. If the new `step_cnt` < latched `n_steps`, go to CLR; otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored.
- `hold`=1 freezes state, all counters and delay pipes. While held, `feed_vld`, `acc_vld`, `integ_vld`, `acc_clr` and `done` are forced to 0. Index outputs keep their values. Releasing `hold` resumes exactly where it stopped.
- Reset (including mid-run) wins over `hold`. All outputs are 0 in the cycle after `rst_n` is sampled low; state is IDLE and the delay pipes are cleared.
- All index arithmetic is unsigned modulo 2^IDX_W, and no index exceeds N_BODIES−1.

## Timing
- `start` sampled at edge 0 → CLR in cycle 1 → FEED in cycles 2..T+2 → DRAIN for ARR_LAT cycles → INTEG for N_BODIES cycles.
- Cycles per step: 2 + T + ARR_LAT + N_BODIES.
- N_BODIES=4, ARR_LAT=2, T=4: CLR at cycle 1, FEED at 2–6, DRAIN at 7–8, INTEG at 9–12, DONE at 13 (for `n_steps`=1).
- `acc_vld` lane 0 is high in cycles 4–7; lane 1 is high in cycles 5–8.
- `n_steps`=0: `done` is high in cycle 1 and `busy` in cycle 1 only.

## Configuration
- `NBODY_SCHED_SYMM_EN` defined: only tiles with bj ≥ bi are issued (upper triangle including diagonal), T = M(M+1)/2 with M = N_BODIES/2. The accumulator uses `out_pd` for the reaction term.
- Macro not defined: all tiles are issued, T = M².

## Structure
- Package `nbody_sched_pkg`: state enum `sched_state_t`, and a function returning tile count T for a given N_BODIES and symmetry mode.
- Sub-module `nbody_lane_delay`: parameterised ARR_LAT-deep shift register carrying {vld, i_idx, j_idx} per lane, with hold-enable and synchronous clear. Instantiated once per lane.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles. All outputs must be 0 and `busy`=0.
- Single step (N=4, `n_steps`=1):
  - Lane 0 feeds (i,j) = (0,0),(0,2),(2,0),(2,2) in cycles 2–5.
  - Lane 1 feeds (1,1),(1,3),(3,1),(3,3) in cycles 3–6.
  - `integ_idx` = 0,1,2,3 in cycles 9–12; `done` in cycle 13.
- Multi-step: `n_steps`=3 → `acc_clr` at cycles 1, 13 and 25, `done` at cycle 37, `step_cnt`=3.
- Hold: assert `hold` in cycles 4–6. Every strobe is 0 during those cycles and the whole schedule shifts by exactly 3 cycles (`done` at 16).
- Edge cases:
  - `n_steps`=0 → `done` in cycle 1 and no feed strobes.
  - `start` pulsed during FEED is ignored.
  - `rst_n` low in cycle 8 → IDLE, `acc_vld`=0 in cycle 9.
- With `NBODY_SCHED_SYMM_EN`: lane 0 feeds only (0,0),(0,2),(2,2); INTEG starts at cycle 8 and `done` comes at cycle 12.

Source files
------------

// File: rtl/nbody_sched_pkg.sv
// Shared types and helpers for the 2x2 n-body sequencing controller.
package nbody_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_INTEG = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

    // Number of 2x2 tiles walked per step: the full M x M grid, or only
    // the upper triangle (diagonal included) when symmetry is exploited.
    function automatic int tile_count(input int n_bodies, input bit symm);
        int m;
        m = n_bodies / 2;
        return symm ? (m * (m + 1)) / 2 : m * m;
    endfunction

endpackage

// File: rtl/nbody_lane_delay.sv
// Fixed-latency shift register carrying {vld, i_idx, j_idx} for one array
// lane, so the accumulator strobes line up with the array output.
module nbody_lane_delay #(
    parameter int LAT   = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] i_idx_i,
    input  logic [IDX_W-1:0] j_idx_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] i_idx_o,
    output logic [IDX_W-1:0] j_idx_o
);

    localparam int W = 1 + 2 * IDX_W;

    logic [W-1:0] pipe_q [LAT];

    // Shift when enabled; a synchronous clear empties every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= {vld_i, i_idx_i, j_idx_i};
            for (int k = 1; k < LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign {vld_o, i_idx_o, j_idx_o} = pipe_q[LAT-1];

endmodule

// File: rtl/nbody_2x2_scheduler.sv
// Step sequencer for the 2x2 systolic n-body array and Verlet integrator.
// Build option: define NBODY_SCHED_SYMM_EN to issue only upper-triangle
// tiles (bj >= bi); otherwise every tile of the interaction matrix is issued.
module nbody_2x2_scheduler
    import nbody_sched_pkg::*;
#(
    parameter int N_BODIES = 4,
    parameter int ARR_LAT  = 2,
    parameter int IDX_W    = $clog2(N_BODIES),
    parameter int STEP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic [STEP_W-1:0] n_steps,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt,
    output logic              acc_clr,
    output logic [1:0]        feed_vld,
    output logic [IDX_W-1:0]  feed_i_idx0,
    output logic [IDX_W-1:0]  feed_i_idx1,
    output logic [IDX_W-1:0]  feed_j_idx0,
    output logic [IDX_W-1:0]  feed_j_idx1,
    output logic [1:0]        acc_vld,
    output logic [IDX_W-1:0]  acc_i_idx0,
    output logic [IDX_W-1:0]  acc_i_idx1,
    output logic [IDX_W-1:0]  acc_j_idx0,
    output logic [IDX_W-1:0]  acc_j_idx1,
    output logic              integ_vld,
    output logic [IDX_W-1:0]  integ_idx
);

`ifdef NBODY_SCHED_SYMM_EN
    localparam bit SYMM = 1'b1;
`else
    localparam bit SYMM = 1'b0;
`endif

    localparam int M  = N_BODIES / 2;
    localparam int T  = tile_count(N_BODIES, SYMM);
    localparam int TW = $clog2(T + 1);
    localparam int DW = $clog2(ARR_LAT + 1);

    sched_state_t      state_q, state_d;
    logic [STEP_W-1:0] n_steps_q, n_steps_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TW-1:0]     t_q, t_d;
    logic [IDX_W-1:0]  bi_q, bi_d, bj_q, bj_d;       // tile on lane 0
    logic [IDX_W-1:0]  l1_bi_q, l1_bi_d, l1_bj_q, l1_bj_d; // previous tile, lane 1
    logic [DW-1:0]     drain_q, drain_d;
    logic [IDX_W-1:0]  integ_q, integ_d;

    logic lane0_vld, lane1_vld;

    // Next-state and counter logic; lane validity follows the one-cycle skew.
    always_comb begin
        state_d   = state_q;
        n_steps_d = n_steps_q;
        step_d    = step_q;
        t_d       = t_q;
        bi_d      = bi_q;
        bj_d      = bj_q;
        l1_bi_d   = l1_bi_q;
        l1_bj_d   = l1_bj_q;
        drain_d   = drain_q;
        integ_d   = integ_q;
        lane0_vld = 1'b0;
        lane1_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_d = '0;
                    if (n_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        n_steps_d = n_steps;
                        state_d   = S_CLR;
                    end
                end
            end
            S_CLR: begin
                t_d     = '0;
                bi_d    = '0;
                bj_d    = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                lane0_vld = (t_q < TW'(T));
                lane1_vld = (t_q != '0);
                l1_bi_d   = bi_q;
                l1_bj_d   = bj_q;
                if (lane0_vld) begin
                    if (bj_q == IDX_W'(M - 1)) begin
                        bi_d = bi_q + 1'b1;
                        bj_d = SYMM ? bi_q + 1'b1 : '0;
                    end else begin
                        bj_d = bj_q + 1'b1;
                    end
                end
                if (t_q == TW'(T)) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(ARR_LAT - 1)) begin
                    integ_d = '0;
                    state_d = S_INTEG;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_INTEG: begin
                if (integ_q == IDX_W'(N_BODIES - 1)) begin
                    step_d  = step_q + 1'b1;
                    state_d = (step_d < n_steps_q) ? S_CLR : S_DONE;
                end else begin
                    integ_d = integ_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register: reset dominates, hold freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_steps_q <= '0;
            step_q    <= '0;
            t_q       <= '0;
            bi_q      <= '0;
            bj_q      <= '0;
            l1_bi_q   <= '0;
            l1_bj_q   <= '0;
            drain_q   <= '0;
            integ_q   <= '0;
        end else if (!hold) begin
            state_q   <= state_d;
            n_steps_q <= n_steps_d;
            step_q    <= step_d;
            t_q       <= t_d;
            bi_q      <= bi_d;
            bj_q      <= bj_d;
            l1_bi_q   <= l1_bi_d;
            l1_bj_q   <= l1_bj_d;
            drain_q   <= drain_d;
            integ_q   <= integ_d;
        end
    end

    // Idle lanes present index 0 so no out-of-range tile index escapes.
    assign feed_i_idx0 = lane0_vld ? (bi_q << 1) : '0;
    assign feed_j_idx0 = lane0_vld ? (bj_q << 1) : '0;
    assign feed_i_idx1 = lane1_vld ? ((l1_bi_q << 1) | IDX_W'(1)) : '0;
    assign feed_j_idx1 = lane1_vld ? ((l1_bj_q << 1) | IDX_W'(1)) : '0;

    assign feed_vld  = {lane1_vld, lane0_vld} & {2{~hold}};
    assign acc_clr   = (state_q == S_CLR) & ~hold;
    assign integ_vld = (state_q == S_INTEG) & ~hold;
    assign integ_idx = (state_q == S_INTEG) ? integ_q : '0;
    assign done      = (state_q == S_DONE) & ~hold;
    assign busy      = (state_q != S_IDLE);
    assign step_cnt  = step_q;

    logic acc_vld0_raw, acc_vld1_raw;

    nbody_lane_delay #(.LAT(ARR_LAT), .IDX_W(IDX_W)) u_delay0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (~hold),
        .vld_i   (lane0_vld),
        .i_idx_i (feed_i_idx0),
        .j_idx_i (feed_j_idx0),
        .vld_o   (acc_vld0_raw),
        .i_idx_o (acc_i_idx0),
        .j_idx_o (acc_j_idx0)
    );

    nbody_lane_delay #(.LAT(ARR_LAT), .IDX_W(IDX_W)) u_delay1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (~hold),
        .vld_i   (lane1_vld),
        .i_idx_i (feed_i_idx1),
        .j_idx_i (feed_j_idx1),
        .vld_o   (acc_vld1_raw),
        .i_idx_o (acc_i_idx1),
        .j_idx_o (acc_j_idx1)
    );

    assign acc_vld = {acc_vld1_raw, acc_vld0_raw} & {2{~hold}};

endmodule
